// File: rtl/mpc_rob.sv
// mpc_rob: per-channel reorder buffer releasing out-of-order bank fills in allocation order
module mpc_rob #(
  parameter int NumChannels = 4,
  parameter int RobSize = 8,
  parameter int DataWidth = 128,
  localparam int RobWidth = $clog2(RobSize),
  localparam int ChanWidth = NumChannels > 1 ? $clog2(NumChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumChannels-1:0]           alloc_valid_i,
  output logic [NumChannels-1:0]           alloc_ready_o,
  output logic [NumChannels*RobWidth-1:0]  alloc_id_o,
  input  logic                             fill_valid_i,
  input  logic [ChanWidth-1:0]             fill_channel_i,
  input  logic [RobWidth-1:0]              fill_id_i,
  input  logic [DataWidth-1:0]             fill_data_i,
  output logic [NumChannels-1:0]           rsp_valid_o,
  input  logic [NumChannels-1:0]           rsp_ready_i,
  output logic [NumChannels*DataWidth-1:0] rsp_data_o,
  output logic                             err_o
);
  logic [NumChannels-1:0] w_fill_ok;
  logic r_err;
  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [RobWidth:0] r_head, r_tail;
    logic [RobSize-1:0] r_alloc, r_filled;
    logic [DataWidth-1:0] r_data [RobSize];
    logic [RobWidth-1:0] w_h, w_t;
    logic w_full, w_push, w_pop;
    assign w_h = r_head[RobWidth-1:0];
    assign w_t = r_tail[RobWidth-1:0];
    assign w_full = (w_h == w_t) && (r_head[RobWidth] != r_tail[RobWidth]);
    assign w_push = alloc_valid_i[c] && !w_full;
    assign w_pop = rsp_valid_o[c] && rsp_ready_i[c];
    assign alloc_ready_o[c] = !w_full;
    assign alloc_id_o[c*RobWidth +: RobWidth] = w_t;
    assign rsp_valid_o[c] = r_alloc[w_h] && r_filled[w_h];
    assign rsp_data_o[c*DataWidth +: DataWidth] = r_data[w_h];
    // only an allocated, still-empty entry may accept a fill
    assign w_fill_ok[c] = fill_valid_i && (fill_channel_i == ChanWidth'(c)) &&
                          r_alloc[fill_id_i] && !r_filled[fill_id_i];
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_head <= '0;
        r_tail <= '0;
        r_alloc <= '0;
        r_filled <= '0;
      end else begin
        if (w_push) begin
          r_alloc[w_t] <= 1'b1;
          r_filled[w_t] <= 1'b0;
          r_tail <= r_tail + (RobWidth+1)'(1);
        end
        if (w_fill_ok[c]) r_filled[fill_id_i] <= 1'b1;
        if (w_pop) begin
          r_alloc[w_h] <= 1'b0;
          r_filled[w_h] <= 1'b0;
          r_head <= r_head + (RobWidth+1)'(1);
        end
      end
    end
    always_ff @(posedge clk_i) if (w_fill_ok[c]) r_data[fill_id_i] <= fill_data_i;
  end
  always_ff @(posedge clk_i) r_err <= rst_i ? 1'b0 : (r_err || (fill_valid_i && !(|w_fill_ok)));
  assign err_o = r_err;
endmodule

// File: tb/tb_mpc_rob.sv
// tb_mpc_rob: directed checks of ordering, full/wrap, misuse and reset for mpc_rob
module tb_mpc_rob;
  logic clk = 0, rst = 0;
  logic [3:0] alloc_valid, alloc_ready, rsp_valid, rsp_ready;
  logic [11:0] alloc_id;
  logic fill_valid, err;
  logic [1:0] fill_ch;
  logic [2:0] fill_id;
  logic [127:0] fill_data;
  logic [511:0] rsp_data;
  int ntests = 0, nfail = 0;
  mpc_rob dut (
    .clk_i(clk), .rst_i(rst), .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
    .alloc_id_o(alloc_id), .fill_valid_i(fill_valid), .fill_channel_i(fill_ch),
    .fill_id_i(fill_id), .fill_data_i(fill_data), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    alloc_valid = 0;
    fill_valid = 0;
    fill_ch = 0;
    fill_id = 0;
    fill_data = 0;
    rsp_ready = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic fill(input int c, input int id, input logic [127:0] d);
    fill_valid = 1;
    fill_ch = 2'(c);
    fill_id = 3'(id);
    fill_data = d;
  endtask
  task automatic test_reset();
    do_reset();
    ntests++; if (alloc_ready !== 4'hf) begin nfail++; $display("FAIL reset_ready got %h exp f", alloc_ready); end
    ntests++; if (alloc_id !== 12'h0) begin nfail++; $display("FAIL reset_id got %h exp 0", alloc_id); end
    ntests++; if (rsp_valid !== 4'h0) begin nfail++; $display("FAIL reset_rsp_valid got %h exp 0", rsp_valid); end
    ntests++; if (err !== 1'b0) begin nfail++; $display("FAIL reset_err got %b exp 0", err); end
  endtask
  task automatic test_in_order();
    do_reset();
    alloc_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      ntests++; if (alloc_id[2:0] !== 3'(i)) begin nfail++; $display("FAIL inord_id got %0d exp %0d", alloc_id[2:0], i); end
      tick();
    end
    alloc_valid = 0;
    rsp_ready = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) fill(0, i, 128'hA0 + 128'(i)); else fill_valid = 0;
      if (i == 0) begin
        ntests++; if (rsp_valid !== 4'b0) begin nfail++; $display("FAIL inord_early got %h exp 0", rsp_valid); end
      end else begin
        ntests++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[127:0] !== 128'hA0 + 128'(i - 1)) begin
          nfail++; $display("FAIL inord_rsp%0d got v=%b d=%h exp v=1 d=%h", i - 1, rsp_valid[0], rsp_data[127:0], 128'hA0 + 128'(i - 1));
        end
      end
      tick();
    end
    ntests++; if (rsp_valid !== 4'b0) begin nfail++; $display("FAIL inord_after got %h exp 0", rsp_valid); end
  endtask
  task automatic test_out_of_order();
    int ord [4] = '{3, 1, 2, 0};
    do_reset();
    alloc_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      ntests++; if (alloc_id[5:3] !== 3'(i)) begin nfail++; $display("FAIL ooo_id got %0d exp %0d", alloc_id[5:3], i); end
      tick();
    end
    alloc_valid = 0;
    rsp_ready = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      fill(1, ord[k], 128'hB0 + 128'(ord[k]));
      ntests++; if (rsp_valid !== 4'b0) begin nfail++; $display("FAIL ooo_hold%0d got %h exp 0", k, rsp_valid); end
      tick();
    end
    fill_valid = 0;
    for (int k = 0; k < 4; k++) begin
      ntests++;
      if (rsp_valid[1] !== 1'b1 || rsp_data[255:128] !== 128'hB0 + 128'(k)) begin
        nfail++; $display("FAIL ooo_rsp%0d got v=%b d=%h exp v=1 d=%h", k, rsp_valid[1], rsp_data[255:128], 128'hB0 + 128'(k));
      end
      tick();
    end
    ntests++; if (rsp_valid !== 4'b0) begin nfail++; $display("FAIL ooo_after got %h exp 0", rsp_valid); end
  endtask
  task automatic test_full_wrap();
    int h = 1, t = 0;
    do_reset();
    alloc_valid = 4'b0001;
    for (int i = 0; i < 8; i++) tick();
    ntests++; if (alloc_ready[0] !== 1'b0) begin nfail++; $display("FAIL full_ready got %b exp 0", alloc_ready[0]); end
    fill(0, 0, 128'hF0);
    tick();
    fill_valid = 0;
    rsp_ready = 4'b0001;
    ntests++;
    if (alloc_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1) begin
      nfail++; $display("FAIL full_drain_cycle got ready=%b v=%b exp ready=0 v=1", alloc_ready[0], rsp_valid[0]);
    end
    tick();
    ntests++;
    if (alloc_ready[0] !== 1'b1 || alloc_id[2:0] !== 3'd0) begin
      nfail++; $display("FAIL full_reopen got ready=%b id=%0d exp ready=1 id=0", alloc_ready[0], alloc_id[2:0]);
    end
    for (int k = 0; k < 40; k++) begin
      alloc_valid = 4'b0001;
      rsp_ready = 0;
      fill(0, h, 128'hC00 + 128'(k));
      ntests++;
      if (alloc_ready[0] !== 1'b1 || alloc_id[2:0] !== 3'(t)) begin
        nfail++; $display("FAIL wrap_alloc%0d got ready=%b id=%0d exp ready=1 id=%0d", k, alloc_ready[0], alloc_id[2:0], t);
      end
      tick();
      t = (t + 1) % 8;
      alloc_valid = 0;
      fill_valid = 0;
      rsp_ready = 4'b0001;
      ntests++;
      if (rsp_valid[0] !== 1'b1 || rsp_data[127:0] !== 128'hC00 + 128'(k)) begin
        nfail++; $display("FAIL wrap_rsp%0d got v=%b d=%h exp v=1 d=%h", k, rsp_valid[0], rsp_data[127:0], 128'hC00 + 128'(k));
      end
      tick();
      h = (h + 1) % 8;
    end
    ntests++; if (err !== 1'b0) begin nfail++; $display("FAIL wrap_err got %b exp 0", err); end
  endtask
  task automatic test_misuse();
    do_reset();
    fill(2, 5, 128'h11);
    tick();
    fill_valid = 0;
    ntests++; if (err !== 1'b1) begin nfail++; $display("FAIL mis_unalloc got %b exp 1", err); end
    ntests++; if (rsp_valid !== 4'b0) begin nfail++; $display("FAIL mis_unalloc_rsp got %h exp 0", rsp_valid); end
    alloc_valid = 4'b0001;
    tick();
    alloc_valid = 0;
    tick();
    ntests++; if (err !== 1'b1) begin nfail++; $display("FAIL mis_sticky got %b exp 1", err); end
    do_reset();
    alloc_valid = 4'b0001;
    tick();
    alloc_valid = 0;
    fill(0, 0, 128'h55);
    tick();
    fill(0, 0, 128'h66);
    ntests++; if (err !== 1'b0) begin nfail++; $display("FAIL mis_legal got %b exp 0", err); end
    tick();
    fill_valid = 0;
    ntests++; if (err !== 1'b1) begin nfail++; $display("FAIL mis_dup got %b exp 1", err); end
    ntests++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[127:0] !== 128'h55) begin
      nfail++; $display("FAIL mis_data got v=%b d=%h exp v=1 d=55", rsp_valid[0], rsp_data[127:0]);
    end
    do_reset();
    alloc_valid = 4'b1000;
    fill(3, 0, 128'h77);
    tick();
    idle();
    ntests++; if (err !== 1'b1) begin nfail++; $display("FAIL mis_same_cycle got %b exp 1", err); end
    ntests++; if (rsp_valid[3] !== 1'b0) begin nfail++; $display("FAIL mis_same_cycle_rsp got %b exp 0", rsp_valid[3]); end
  endtask
  task automatic test_multi_channel();
    int m_head [4], m_tail [4], m_cnt [4], nalloc [4], nrsp [4];
    bit m_alloc [4][8], m_filled [4][8];
    int m_seq [4][8];
    bit pop [4];
    int fc, fid, off;
    bit fv;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      m_head[c] = 0; m_tail[c] = 0; m_cnt[c] = 0; nalloc[c] = 0; nrsp[c] = 0;
      for (int e = 0; e < 8; e++) begin m_alloc[c][e] = 0; m_filled[c][e] = 0; m_seq[c][e] = 0; end
    end
    alloc_valid = 4'hf;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rsp_ready = 4'($urandom_range(0, 15));
      for (int c = 0; c < 4; c++) begin
        ntests++;
        if (alloc_ready[c] !== (m_cnt[c] < 8) || alloc_id[c*3 +: 3] !== 3'(m_tail[c])) begin
          nfail++; $display("FAIL multi_alloc ch%0d got ready=%b id=%0d exp ready=%b id=%0d", c, alloc_ready[c], alloc_id[c*3 +: 3], m_cnt[c] < 8, m_tail[c]);
        end
        pop[c] = m_alloc[c][m_head[c]] && m_filled[c][m_head[c]];
        ntests++;
        if (rsp_valid[c] !== pop[c] || (pop[c] && rsp_data[c*128 +: 128] !== {96'(c), 32'(nrsp[c])})) begin
          nfail++; $display("FAIL multi_rsp ch%0d got v=%b d=%h exp v=%b d=%h", c, rsp_valid[c], rsp_data[c*128 +: 128], pop[c], {96'(c), 32'(nrsp[c])});
        end
        pop[c] = pop[c] && rsp_ready[c];
      end
      fv = 0;
      fc = $urandom_range(0, 3);
      off = $urandom_range(0, 7);
      for (int j = 0; j < 8; j++) begin
        if (!fv && m_alloc[fc][(off + j) % 8] && !m_filled[fc][(off + j) % 8]) begin
          fv = 1;
          fid = (off + j) % 8;
        end
      end
      if (fv) fill(fc, fid, {96'(fc), 32'(m_seq[fc][fid])}); else fill_valid = 0;
      tick();
      if (fv) m_filled[fc][fid] = 1;
      for (int c = 0; c < 4; c++) begin
        if (m_cnt[c] < 8) begin
          m_alloc[c][m_tail[c]] = 1;
          m_filled[c][m_tail[c]] = 0;
          m_seq[c][m_tail[c]] = nalloc[c];
          nalloc[c]++;
          m_tail[c] = (m_tail[c] + 1) % 8;
          m_cnt[c]++;
        end
        if (pop[c]) begin
          m_alloc[c][m_head[c]] = 0;
          m_filled[c][m_head[c]] = 0;
          m_head[c] = (m_head[c] + 1) % 8;
          m_cnt[c]--;
          nrsp[c]++;
        end
      end
    end
    idle();
    ntests++; if (err !== 1'b0) begin nfail++; $display("FAIL multi_err got %b exp 0", err); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    alloc_valid = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    alloc_valid = 0;
    fill(0, 0, 128'hD0);
    tick();
    fill(1, 0, 128'hD1);
    tick();
    fill_valid = 0;
    ntests++;
    if (rsp_valid[0] !== 1'b1 || err !== 1'b1 || alloc_id[2:0] !== 3'd5) begin
      nfail++; $display("FAIL rmid_pre got v=%b err=%b id=%0d exp v=1 err=1 id=5", rsp_valid[0], err, alloc_id[2:0]);
    end
    rst = 1;
    tick();
    rst = 0;
    ntests++; if (rsp_valid !== 4'b0) begin nfail++; $display("FAIL rmid_rsp got %h exp 0", rsp_valid); end
    ntests++; if (alloc_ready !== 4'hf) begin nfail++; $display("FAIL rmid_ready got %h exp f", alloc_ready); end
    ntests++; if (alloc_id[2:0] !== 3'd0) begin nfail++; $display("FAIL rmid_id got %0d exp 0", alloc_id[2:0]); end
    ntests++; if (err !== 1'b0) begin nfail++; $display("FAIL rmid_err got %b exp 0", err); end
  endtask
  initial begin
    idle();
    test_reset();
    test_in_order();
    test_out_of_order();
    test_full_wrap();
    test_misuse();
    test_multi_channel();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/mpc_rob.md
# mpc_rob

Parametrised per-channel reorder buffer for the multi-port cache. Each channel allocates an in-order tag (`rob_id`) when it issues a load. Banks return load data out of order, tagged with channel and `rob_id`. The block releases data to each channel strictly in allocation order. It generalises the fixed 3-bit `rob_id` / 2-bit `channel_id` response path to any channel count, depth and data width, and adds misuse detection.

## Interface
Parameters:
- `NumChannels`, 4: number of independent channel ROBs (≥1).
- `RobSize`, 8: entries per channel, power of two, ≥2.
- `DataWidth`, 128: response data width.
- Derived: `RobWidth` = $clog2(RobSize); `ChanWidth` = NumChannels>1 ? $clog2(NumChannels) : 1.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `alloc_valid_i`  in  NumChannels  per-channel allocation request.
- `alloc_ready_o`  out  NumChannels  channel ROB not full.
- `alloc_id_o`  out  NumChannels*RobWidth  id granted to channel c, slice [c*RobWidth +: RobWidth].
- `fill_valid_i`  in  1  bank response valid (one per cycle, always accepted).
- `fill_channel_i`  in  ChanWidth  target channel.
- `fill_id_i`  in  RobWidth  target entry.
- `fill_data_i`  in  DataWidth  load data.
- `rsp_valid_o`  out  NumChannels  head entry of channel c filled.
- `rsp_ready_i`  in  NumChannels  channel c consumes head.
- `rsp_data_o`  out  NumChannels*DataWidth  head data of channel c.
- `err_o`  out  1  sticky misuse flag.

## Operation
- Per channel: head and tail pointers of RobWidth+1 bits (extra wrap bit), an `alloc` bit and a `filled` bit per entry, and a DataWidth data array.
- empty = (head == tail). full = low bits equal and wrap bits differ.
- Allocate: `alloc_id_o` = tail[RobWidth-1:0] (combinational). `alloc_ready_o` = !full. On alloc_valid && alloc_ready: set alloc[tail], clear filled[tail], tail+1 (mod 2^(RobWidth+1)).
- Fill: on fill_valid_i, let entry e = (fill_channel_i, fill_id_i).
  - Legal when alloc[e] && !filled[e]: write data, set filled[e].
  - Otherwise, or when fill_channel_i ≥ NumChannels: drop the write and set `err_o`.
- Drain: `rsp_valid_o[c]` = alloc[head] && filled[head]. `rsp_data_o` = data[head]. On valid && ready: clear alloc/filled[head], head+1.
- Simultaneous events within one channel in one cycle:
  - Alloc and drain: both take effect. `alloc_ready` is computed from pre-edge state only, with no bypass. A full ROB stays not-ready in the drain cycle.
  - Fill and drain of different entries: both take effect.
  - Fill targeting the entry being allocated in the same cycle: illegal (entry not yet allocated), so `err_o`.
- Channels are fully independent except for the shared fill port.
- `err_o` clears only on reset.

## Timing
- Reset values: head = tail = 0, all alloc/filled = 0, `alloc_ready_o` = all 1s, `alloc_id_o` = 0, `rsp_valid_o` = 0, `err_o` = 0. Data array is not reset. `rsp_data_o` is don't-care while `rsp_valid_o` is 0.
- Alloc→id: same cycle (combinational from tail).
- Fill→rsp: fill sampled at edge t gives `rsp_valid_o` high in cycle t+1 when the entry is the head. There is no combinational fill-to-rsp bypass.
- Drain throughput: one entry per channel per cycle. Drained entry is reallocatable from the next cycle.
- Once asserted, `rsp_valid_o`/`rsp_data_o` stay stable until handshake.
- Reset mid-operation discards all outstanding entries and errors within one cycle. There are no outputs from pre-reset state after the reset edge.
- Pointer wrap at 2^(RobWidth+1) is seamless and never corrupts full/empty.

## Test plan
- In-order: ch0 allocates ids 0,1,2. Fill 0,1,2 with 0xA0,0xA1,0xA2, rsp_ready=1 → rsp emits 0xA0,0xA1,0xA2 on consecutive cycles, first one cycle after fill 0.
- Out-of-order: ch1 allocates 0..3. Fill ids 3,1,2,0 → no rsp until id 0 filled. Then data for ids 0,1,2,3 in order on four consecutive cycles.
- Full/wrap: RobSize=8. Allocate 8 → alloc_ready_o[0]=0. Fill+drain one → ready returns the next cycle with alloc_id=0. Repeat for 40 transactions → in-order data, err_o=0.
- Misuse: fill unallocated ch2 id5, then fill ch0 id0 twice → first fill and duplicate dropped, err_o=1 and stays 1, stored data unchanged.
- Multi-channel: all 4 channels allocate each cycle while random fills interleave and rsp_ready toggles randomly → each channel's output order equals its allocation order, with no cross-channel data.
- Reset mid-flight: 5 outstanding entries on ch0, rst_i for 1 cycle → next cycle rsp_valid_o=0, alloc_ready_o=all 1s, alloc_id ch0=0, err_o=0.
